shift_exec_stage: RTL and testbench

- Two-stage pipelined execute stage for shift instructions (SLL/SRL/SRA/SLLV/SRLV/SRAV, plus rotate-left).
- Sits between decode/operand-read and writeback, and wraps the combinational barrel left shifter.
- Right shifts and rotates are built around the left shifter by bit reversal and masking.
- Valid/ready handshakes on both sides give full backpressure at one op per cycle throughput.

---
 rtl/shift_exec_stage.sv | 124 ++++++++++++
 tb/tb_shift_exec_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_stage.sv
// Two-stage shift execute stage: S1 holds the decoded op, S2 holds the result.
// Right shifts and rotates reuse a left barrel shifter via bit reversal.

module shift_exec_barrel (
    input  logic [31:0] din,
    input  logic [4:0]  amt,
    output logic [31:0] dout
);
    logic [5:0][31:0] stg;

    assign stg[0] = din;

    genvar k;
    generate
        for (k = 0; k < 5; k++) begin : g_stage
            assign stg[k+1] = amt[k] ? (stg[k] << (2 ** k)) : stg[k];
        end
    endgenerate

    assign dout = stg[5];
endmodule

module shift_exec_stage #(
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      data_operandA,
    input  logic [4:0]       ctrl_shiftamt,
    input  logic [1:0]       ctrl_shiftop,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      data_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      ops_done
);
    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTL = 2'b11;

    typedef struct packed {
        logic [31:0]      opa;
        logic [4:0]       amt;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
    } s2_t;

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    s1_t         s1_q;
    s2_t         s2_q;
    logic        s1_valid, s2_valid;
    logic        s1_ready, s2_ready;
    logic [31:0] shl_in, shl_out, rot_out, rot_hi, sra_mask, res;
    logic [4:0]  rot_amt;

    assign s2_ready  = !s2_valid || out_ready;
    assign s1_ready  = !s1_valid || s2_ready;
    assign in_ready  = s1_ready;
    assign out_valid = s2_valid;
    assign data_result = s2_q.res;
    assign out_tag     = s2_q.tag;

    // Right shifts run through the left shifter on the reversed operand.
    assign shl_in = (s1_q.op == OP_SRL || s1_q.op == OP_SRA) ? rev32(s1_q.opa) : s1_q.opa;

    shift_exec_barrel u_shl (.din(shl_in), .amt(s1_q.amt), .dout(shl_out));

    // Low half of a rotate is opa >> (32-amt); amt=0 degenerates to opa, harmless under OR.
    assign rot_amt = 5'd0 - s1_q.amt;
    shift_exec_barrel u_rot (.din(rev32(s1_q.opa)), .amt(rot_amt), .dout(rot_out));
    assign rot_hi   = rev32(rot_out);
    assign sra_mask = ~(32'hFFFF_FFFF >> s1_q.amt);

    always_comb begin
        res = shl_out;
        case (s1_q.op)
            OP_SLL:  res = shl_out;
            OP_SRL:  res = rev32(shl_out);
            OP_SRA:  res = rev32(shl_out) | (s1_q.opa[31] ? sra_mask : 32'd0);
            OP_ROTL: res = shl_out | rot_hi;
            default: res = shl_out;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            ops_done <= 16'd0;
        end else begin
            if (out_valid && out_ready) ops_done <= ops_done + 16'd1;

            if (ctrl_flush) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (s1_ready) s1_valid <= in_valid;
                if (s2_ready) s2_valid <= s1_valid;
            end

            if (in_valid && s1_ready && !ctrl_flush)
                s1_q <= '{opa: data_operandA, amt: ctrl_shiftamt, op: ctrl_shiftop, tag: in_tag};
            if (s1_valid && s2_ready)
                s2_q <= '{res: res, tag: s1_q.tag};
        end
    end
endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed vectors, stall/flush/reset
// sequences, then randomized traffic against a transaction-level model.

module tb_shift_exec_stage;
    logic        clock, reset_n, ctrl_flush, in_valid, in_ready;
    logic [31:0] data_operandA, data_result;
    logic [4:0]  ctrl_shiftamt, in_tag, out_tag;
    logic [1:0]  ctrl_shiftop;
    logic        out_valid, out_ready;
    logic [15:0] ops_done;

    int tests = 0;
    int fails = 0;

    shift_exec_stage #(.TAG_W(5)) dut (
        .clock(clock), .reset_n(reset_n), .ctrl_flush(ctrl_flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_operandA(data_operandA), .ctrl_shiftamt(ctrl_shiftamt),
        .ctrl_shiftop(ctrl_shiftop), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_result(data_result), .out_tag(out_tag), .ops_done(ops_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  amt;
        logic [31:0] a;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          acc;
    } txn_t;

    vec_t vecs[12];
    vec_t b2b[4];
    txn_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference written from the arithmetic meaning of each op.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                              input logic [4:0] amt);
        logic [63:0] t;
        case (op)
            2'b00:   return a << amt;
            2'b01:   return a >> amt;
            2'b10:   return $unsigned($signed(a) >>> amt);
            default: begin
                t = {a, a} << amt;
                return t[63:32];
            end
        endcase
    endfunction

    task automatic drive(input logic [1:0] op, input logic [4:0] amt, input logic [31:0] a,
                         input logic [4:0] tag);
        in_valid = 1'b1; ctrl_shiftop = op; ctrl_shiftamt = amt; data_operandA = a; in_tag = tag;
    endtask

    logic [15:0] base;
    logic [31:0] held;
    logic        hold, hs_in, hs_out, exp_ov;
    int          cyc, cnt;
    txn_t        t;

    initial begin
        vecs[0]  = '{2'b00, 5'd31, 32'h0000_0001, 5'd3,  32'h8000_0000};
        vecs[1]  = '{2'b01, 5'd4,  32'h8000_0000, 5'd4,  32'h0800_0000};
        vecs[2]  = '{2'b10, 5'd4,  32'h8000_0000, 5'd5,  32'hF800_0000};
        vecs[3]  = '{2'b10, 5'd31, 32'h7FFF_FFFF, 5'd6,  32'h0000_0000};
        vecs[4]  = '{2'b11, 5'd1,  32'h8000_0001, 5'd7,  32'h0000_0003};
        vecs[5]  = '{2'b11, 5'd0,  32'h1234_5678, 5'd8,  32'h1234_5678};
        vecs[6]  = '{2'b00, 5'd0,  32'hDEAD_BEEF, 5'd9,  32'hDEAD_BEEF};
        vecs[7]  = '{2'b01, 5'd0,  32'hDEAD_BEEF, 5'd10, 32'hDEAD_BEEF};
        vecs[8]  = '{2'b10, 5'd31, 32'h8000_0000, 5'd11, 32'hFFFF_FFFF};
        vecs[9]  = '{2'b11, 5'd31, 32'h1234_5678, 5'd12, 32'h091A_2B3C};
        vecs[10] = '{2'b01, 5'd31, 32'hFFFF_FFFF, 5'd13, 32'h0000_0001};
        vecs[11] = '{2'b10, 5'd0,  32'h8000_0000, 5'd14, 32'h8000_0000};

        b2b[0] = '{2'b01, 5'd4,  32'h8000_0000, 5'd1, 32'h0800_0000};
        b2b[1] = '{2'b10, 5'd4,  32'h8000_0000, 5'd2, 32'hF800_0000};
        b2b[2] = '{2'b10, 5'd31, 32'h7FFF_FFFF, 5'd3, 32'h0000_0000};
        b2b[3] = '{2'b11, 5'd8,  32'hAABB_CCDD, 5'd4, 32'hBBCC_DDAA};

        reset_n = 1'b0; ctrl_flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        data_operandA = '0; ctrl_shiftamt = '0; ctrl_shiftop = '0; in_tag = '0;
        repeat (2) @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data", data_result, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_ops_done", ops_done, 0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_in_ready", in_ready, 1);

        // Single ops: accepted at edge N, visible after edge N+1.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].op, vecs[i].amt, vecs[i].a, vecs[i].tag);
            @(negedge clock);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_latency", i), out_valid, 0);
            @(negedge clock);
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_data", i), data_result, vecs[i].exp);
            chk($sformatf("vec%0d_tag", i), out_tag, vecs[i].tag);
        end
        @(negedge clock);

        // Back-to-back: results on consecutive cycles.
        for (int c = 0; c < 6; c++) begin
            if (c >= 2) begin
                chk($sformatf("b2b%0d_valid", c-2), out_valid, 1);
                chk($sformatf("b2b%0d_data", c-2), data_result, b2b[c-2].exp);
                chk($sformatf("b2b%0d_tag", c-2), out_tag, b2b[c-2].tag);
            end
            if (c < 4) drive(b2b[c].op, b2b[c].amt, b2b[c].a, b2b[c].tag);
            else in_valid = 1'b0;
            @(negedge clock);
        end
        chk("b2b_drained", out_valid, 0);

        // Backpressure: three ops into a stalled stage.
        base = ops_done;
        out_ready = 1'b0;
        drive(2'b00, 5'd1, 32'd1, 5'd1);
        #1 chk("stall_rdy1", in_ready, 1);
        @(negedge clock);
        drive(2'b00, 5'd1, 32'd2, 5'd2);
        #1 chk("stall_rdy2", in_ready, 1);
        @(negedge clock);
        drive(2'b00, 5'd1, 32'd3, 5'd3);
        #1 chk("stall_rdy3", in_ready, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            chk("stall_hold_valid", out_valid, 1);
            chk("stall_hold_data", data_result, 32'd2);
            chk("stall_hold_tag", out_tag, 1);
            chk("stall_hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        #1 chk("drain_tag1", out_tag, 1);
        @(negedge clock);
        in_valid = 1'b0;
        chk("drain_tag2", out_tag, 2);
        chk("drain_data2", data_result, 32'd4);
        @(negedge clock);
        chk("drain_tag3", out_tag, 3);
        chk("drain_data3", data_result, 32'd6);
        @(negedge clock);
        chk("drain_empty", out_valid, 0);
        chk("drain_count", ops_done, base + 16'd3);

        // Flush with two ops in flight.
        out_ready = 1'b0;
        base = ops_done;
        drive(2'b00, 5'd4, 32'h11, 5'd20);
        @(negedge clock);
        drive(2'b00, 5'd4, 32'h22, 5'd21);
        @(negedge clock);
        in_valid = 1'b0;
        chk("flush_pre_valid", out_valid, 1);
        ctrl_flush = 1'b1;
        @(negedge clock);
        ctrl_flush = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_rdy", in_ready, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("flush_gone", out_valid, 0);
        end
        chk("flush_count", ops_done, base);

        // A handshake in the flush cycle still counts.
        drive(2'b00, 5'd0, 32'h33, 5'd22);
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        chk("flushhs_valid", out_valid, 1);
        ctrl_flush = 1'b1;
        @(negedge clock);
        ctrl_flush = 1'b0;
        chk("flushhs_count", ops_done, base + 16'd1);

        // Asynchronous reset between edges with ops in flight.
        out_ready = 1'b0;
        drive(2'b00, 5'd1, 32'h5, 5'd23);
        @(negedge clock);
        drive(2'b00, 5'd1, 32'h6, 5'd24);
        @(negedge clock);
        in_valid = 1'b0;
        chk("arst_pre_valid", out_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_count", ops_done, 0);
        chk("arst_data", data_result, 0);
        @(negedge clock);
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        chk("arst_rel_valid", out_valid, 0);
        chk("arst_rel_rdy", in_ready, 1);
        @(negedge clock);
        chk("arst_rel_valid2", out_valid, 0);
        drive(2'b00, 5'd2, 32'h3, 5'd7);
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        chk("arst_new_valid", out_valid, 1);
        chk("arst_new_data", data_result, 32'h0000_000C);
        chk("arst_new_tag", out_tag, 7);

        // Random traffic against the transaction model.
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        q.delete();
        cyc = 0; cnt = 0; hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 1);
            chk("rnd_valid", out_valid, exp_ov);
            if (exp_ov) begin
                chk("rnd_data", data_result, q[0].res);
                chk("rnd_tag", out_tag, q[0].tag);
            end
            chk("rnd_count", ops_done, cnt[15:0]);

            if (!hold) begin
                held = $urandom;
                drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), held,
                      5'($urandom_range(0, 31)));
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready  = ($urandom_range(0, 2) != 0);
            ctrl_flush = ($urandom_range(0, 49) == 0);
            #1;
            chk("rnd_in_ready", in_ready, !(q.size() == 2 && !out_ready));

            hs_in  = in_valid && in_ready && !ctrl_flush;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                void'(q.pop_front());
                cnt++;
            end
            if (ctrl_flush) q.delete();
            else if (hs_in) begin
                t.res = ref_shift(ctrl_shiftop, data_operandA, ctrl_shiftamt);
                t.tag = in_tag;
                t.acc = cyc + 1;
                q.push_back(t);
            end
            hold = in_valid && !in_ready && !ctrl_flush;
            @(negedge clock);
            cyc++;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
